// File: rtl/ooo_types.sv
// Shared out-of-order core types and sizing constants.
// Branch checkpoint constants: NUM_CHECKPOINTS, CKPT_TAG_BITS and the
// checkpoint vector/tag types used by branch_checkpoint_buf.
package ooo_types;

    localparam int unsigned NUM_ARCH_REGS   = 8;
    localparam int unsigned PHYS_REG_BITS   = 6;
    localparam int unsigned NUM_CHECKPOINTS = 4;
    localparam int unsigned CKPT_TAG_BITS   = $clog2(NUM_CHECKPOINTS);

    typedef logic [PHYS_REG_BITS-1:0]                     preg_t;
    typedef logic [NUM_ARCH_REGS-1:0][PHYS_REG_BITS-1:0]  map_t;
    typedef logic [CKPT_TAG_BITS-1:0]                     ckpt_tag_t;
    typedef logic [CKPT_TAG_BITS:0]                       ckpt_cnt_t;
    typedef logic [NUM_CHECKPOINTS-1:0]                   ckpt_vec_t;

    // Decoded outcome of a resolve request against the current valid bits
    typedef enum logic [1:0] {
        RES_NONE       = 2'd0,
        RES_CORRECT    = 2'd1,
        RES_MISPREDICT = 2'd2
    } res_kind_e;

    // Number of set bits in a checkpoint valid vector
    function automatic ckpt_cnt_t count_valid(input ckpt_vec_t v);
        ckpt_cnt_t c;
        c = '0;
        for (int unsigned i = 0; i < NUM_CHECKPOINTS; i++) begin
            if (v[i]) c = c + 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/branch_checkpoint_buf_kill_mask.sv
// Younger-slot kill mask: marks slots start_tag .. tail-1 (circular).
// start_tag == tail means every slot lies in the range (buffer full).
module ckpt_kill_mask
    import ooo_types::*;
(
    input  logic [CKPT_TAG_BITS-1:0]   start_tag,
    input  logic [CKPT_TAG_BITS-1:0]   tail,
    output logic [NUM_CHECKPOINTS-1:0] kill_mask
);

    // Circular distance of each slot from start_tag compared to the span
    always_comb begin
        int unsigned span;
        int unsigned off;
        int unsigned st;
        int unsigned tl;
        kill_mask = '0;
        st   = int'(start_tag);
        tl   = int'(tail);
        span = (tl >= st) ? (tl - st) : (tl + NUM_CHECKPOINTS - st);
        off  = 0;
        for (int unsigned i = 0; i < NUM_CHECKPOINTS; i++) begin
            off = (i >= st) ? (i - st) : (i + NUM_CHECKPOINTS - st);
            kill_mask[i] = (span == 0) || (off < span);
        end
    end

endmodule

// File: rtl/branch_checkpoint_buf.sv
// Branch checkpoint buffer: per-branch rename map snapshots allocated in
// program order, freed on correct resolve, rolled back on mispredict.
// Optional feature macro: CKPT_FREELIST_SNAP_EN (free-list head snapshot).
module branch_checkpoint_buf
    import ooo_types::*;
(
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          alloc_en,
    input  logic [NUM_ARCH_REGS-1:0][PHYS_REG_BITS-1:0]   alloc_map,
`ifdef CKPT_FREELIST_SNAP_EN
    input  logic [PHYS_REG_BITS-1:0]                      alloc_fl_head,
`endif
    output logic                                          alloc_ready,
    output logic [CKPT_TAG_BITS-1:0]                      alloc_tag,
    input  logic                                          resolve_en,
    input  logic [CKPT_TAG_BITS-1:0]                      resolve_tag,
    input  logic                                          resolve_mispredict,
    input  logic                                          flush,
    output logic                                          restore_en,
    output logic [NUM_ARCH_REGS-1:0][PHYS_REG_BITS-1:0]   restore_table,
`ifdef CKPT_FREELIST_SNAP_EN
    output logic [PHYS_REG_BITS-1:0]                      restore_fl_head,
`endif
    output logic [CKPT_TAG_BITS:0]                        ckpt_count
);

    ckpt_vec_t valid_q;
    ckpt_vec_t valid_d;
    ckpt_tag_t tail_q;
    ckpt_tag_t tail_d;
    ckpt_tag_t tail_inc;
    ckpt_vec_t kill_mask;
    res_kind_e res_kind;
    logic      alloc_ok;
    logic      mispredict_ok;

    map_t  snap_mem [NUM_CHECKPOINTS];
`ifdef CKPT_FREELIST_SNAP_EN
    preg_t fl_mem   [NUM_CHECKPOINTS];
`endif

    assign alloc_ready = !valid_q[tail_q];
    assign alloc_tag   = tail_q;
    assign tail_inc    = (tail_q == ckpt_tag_t'(NUM_CHECKPOINTS - 1)) ? '0 : tail_q + 1'b1;

    ckpt_kill_mask u_kill_mask (
        .start_tag (resolve_tag),
        .tail      (tail_q),
        .kill_mask (kill_mask)
    );

    // Classify the resolve against pre-update valid bits
    always_comb begin
        res_kind = RES_NONE;
        if (resolve_en && valid_q[resolve_tag]) begin
            res_kind = resolve_mispredict ? RES_MISPREDICT : RES_CORRECT;
        end
    end

    assign mispredict_ok = (res_kind == RES_MISPREDICT) && !flush;
    assign alloc_ok      = alloc_en && alloc_ready && !flush && (res_kind != RES_MISPREDICT);

    // Next valid vector and tail: flush, then mispredict rollback, then free/alloc
    always_comb begin
        valid_d = valid_q;
        tail_d  = tail_q;
        if (flush) begin
            valid_d = '0;
            tail_d  = '0;
        end else if (res_kind == RES_MISPREDICT) begin
            valid_d = valid_q & ~kill_mask;
            tail_d  = resolve_tag;
        end else begin
            if (res_kind == RES_CORRECT) begin
                valid_d[resolve_tag] = 1'b0;
            end
            if (alloc_ok) begin
                valid_d[tail_q] = 1'b1;
                tail_d          = tail_inc;
            end
        end
    end

    // Valid bits, tail pointer and occupancy count
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            tail_q     <= '0;
            ckpt_count <= '0;
        end else begin
            valid_q    <= valid_d;
            tail_q     <= tail_d;
            ckpt_count <= count_valid(valid_d);
        end
    end

    // Snapshot storage written at the tail on accepted allocation
    always_ff @(posedge clk) begin
        if (!rst && alloc_ok) begin
            snap_mem[tail_q] <= alloc_map;
`ifdef CKPT_FREELIST_SNAP_EN
            fl_mem[tail_q]   <= alloc_fl_head;
`endif
        end
    end

    // One-cycle restore pulse; restore payload holds until the next mispredict
    always_ff @(posedge clk) begin
        if (rst) begin
            restore_en      <= 1'b0;
            restore_table   <= '0;
`ifdef CKPT_FREELIST_SNAP_EN
            restore_fl_head <= '0;
`endif
        end else begin
            restore_en <= mispredict_ok;
            if (mispredict_ok) begin
                restore_table   <= snap_mem[resolve_tag];
`ifdef CKPT_FREELIST_SNAP_EN
                restore_fl_head <= fl_mem[resolve_tag];
`endif
            end
        end
    end

endmodule

// File: tb/tb_branch_checkpoint_buf.sv
// Scoreboard bench for branch_checkpoint_buf: stimulus pushes expected
// status and restore records; a negedge monitor pops and compares them.
module tb_branch_checkpoint_buf;
    import ooo_types::*;

    logic      clk = 1'b0;
    logic      rst;
    logic      alloc_en;
    map_t      alloc_map;
    logic      alloc_ready;
    ckpt_tag_t alloc_tag;
    logic      resolve_en;
    ckpt_tag_t resolve_tag;
    logic      resolve_mispredict;
    logic      flush;
    logic      restore_en;
    map_t      restore_table;
    ckpt_cnt_t ckpt_count;
`ifdef CKPT_FREELIST_SNAP_EN
    preg_t     alloc_fl_head;
    preg_t     restore_fl_head;
`endif

    always #5 clk = ~clk;

    branch_checkpoint_buf dut (
        .clk                (clk),
        .rst                (rst),
        .alloc_en           (alloc_en),
        .alloc_map          (alloc_map),
`ifdef CKPT_FREELIST_SNAP_EN
        .alloc_fl_head      (alloc_fl_head),
`endif
        .alloc_ready        (alloc_ready),
        .alloc_tag          (alloc_tag),
        .resolve_en         (resolve_en),
        .resolve_tag        (resolve_tag),
        .resolve_mispredict (resolve_mispredict),
        .flush              (flush),
        .restore_en         (restore_en),
        .restore_table      (restore_table),
`ifdef CKPT_FREELIST_SNAP_EN
        .restore_fl_head    (restore_fl_head),
`endif
        .ckpt_count         (ckpt_count)
    );

    typedef struct {
        int unsigned cyc;
        int unsigned id;
        ckpt_cnt_t   cnt;
        logic        rdy;
        ckpt_tag_t   tag;
        ckpt_vec_t   vld;
    } st_exp_t;

    typedef struct {
        int unsigned cyc;
        int unsigned id;
        map_t        tbl;
    } rs_exp_t;

    st_exp_t     st_q[$];
    rs_exp_t     rs_q[$];
    int unsigned cyc    = 0;
    int unsigned checks = 0;
    int unsigned passed = 0;
    int unsigned next_id = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare status records due this cycle and every restore pulse
    always @(negedge clk) begin
        st_exp_t e;
        rs_exp_t r;
        while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
            e = st_q.pop_front();
            checks++;
            if (e.cyc != cyc || ckpt_count !== e.cnt || alloc_ready !== e.rdy ||
                alloc_tag !== e.tag || dut.valid_q !== e.vld) begin
                $display("FAIL status#%0d cyc=%0d: got count=%0d ready=%0b tag=%0d valid=%b, want count=%0d ready=%0b tag=%0d valid=%b",
                         e.id, cyc, ckpt_count, alloc_ready, alloc_tag, dut.valid_q,
                         e.cnt, e.rdy, e.tag, e.vld);
            end else begin
                passed++;
            end
        end
        if (restore_en === 1'b1) begin
            checks++;
            if (rs_q.size() == 0) begin
                $display("FAIL restore_unexpected cyc=%0d: got restore_en=1 table=%h, want restore_en=0",
                         cyc, restore_table);
            end else begin
                r = rs_q.pop_front();
                if (r.cyc != cyc || restore_table !== r.tbl) begin
                    $display("FAIL restore#%0d cyc=%0d: got table=%h at cyc %0d, want table=%h at cyc %0d",
                             r.id, cyc, restore_table, cyc, r.tbl, r.cyc);
                end else begin
                    passed++;
                end
            end
        end else if (rs_q.size() > 0 && rs_q[0].cyc <= cyc) begin
            r = rs_q.pop_front();
            checks++;
            $display("FAIL restore_missing#%0d cyc=%0d: got restore_en=%b, want restore_en=1 table=%h",
                     r.id, cyc, restore_en, r.tbl);
        end
    end

    function automatic map_t mk_map(input int unsigned base);
        map_t m;
        for (int unsigned i = 0; i < NUM_ARCH_REGS; i++) begin
            m[i] = preg_t'(base + i);
        end
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
        rst                = 1'b0;
        alloc_en           = 1'b0;
        resolve_en         = 1'b0;
        resolve_mispredict = 1'b0;
        flush              = 1'b0;
    endtask

    task automatic do_alloc(input map_t m);
        alloc_en  = 1'b1;
        alloc_map = m;
`ifdef CKPT_FREELIST_SNAP_EN
        alloc_fl_head = m[0];
`endif
    endtask

    task automatic do_res(input ckpt_tag_t t, input logic mis);
        resolve_en         = 1'b1;
        resolve_tag        = t;
        resolve_mispredict = mis;
    endtask

    // Expected state after the upcoming edge
    task automatic exp_st(input int unsigned cnt, input logic rdy,
                          input int unsigned tag, input logic [3:0] vld);
        st_q.push_back('{cyc: cyc + 1, id: next_id, cnt: ckpt_cnt_t'(cnt),
                         rdy: rdy, tag: ckpt_tag_t'(tag), vld: ckpt_vec_t'(vld)});
        next_id++;
    endtask

    // Expected restore pulse one cycle after the upcoming edge's mispredict
    task automatic exp_rs(input map_t t);
        rs_q.push_back('{cyc: cyc + 1, id: next_id, tbl: t});
        next_id++;
    endtask

    map_t map_a, map_b, map_c, map_d, map_e, map_p, map_q, map_x, map_y;

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of stimulus, want completion before 100000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        map_a = mk_map(1);  map_b = mk_map(9);  map_c = mk_map(17);
        map_d = mk_map(25); map_e = mk_map(33); map_p = mk_map(41);
        map_q = mk_map(49); map_x = mk_map(2);  map_y = mk_map(10);

        rst = 1'b1; alloc_en = 1'b0; alloc_map = '0; resolve_en = 1'b0;
        resolve_tag = '0; resolve_mispredict = 1'b0; flush = 1'b0;
`ifdef CKPT_FREELIST_SNAP_EN
        alloc_fl_head = '0;
`endif
        tick();
        rst = 1'b1; exp_st(0, 1, 0, 4'b0000); tick();

        // Fill from reset, then an over-full alloc
        do_alloc(map_a); exp_st(1, 1, 1, 4'b0001); tick();
        do_alloc(map_b); exp_st(2, 1, 2, 4'b0011); tick();
        do_alloc(map_c); exp_st(3, 1, 3, 4'b0111); tick();
        do_alloc(map_d); exp_st(4, 0, 0, 4'b1111); tick();
        do_alloc(map_e); exp_st(4, 0, 0, 4'b1111); tick();

        // Correct resolve in the middle
        do_res(1, 1'b0); exp_st(3, 0, 0, 4'b1101); tick();

        // Reset beats a mispredict in the same cycle
        rst = 1'b1; do_res(2, 1'b1); exp_st(0, 1, 0, 4'b0000); tick();

        // Mispredict on tag 1 restores B
        do_alloc(map_a); exp_st(1, 1, 1, 4'b0001); tick();
        do_alloc(map_b); exp_st(2, 1, 2, 4'b0011); tick();
        do_alloc(map_c); exp_st(3, 1, 3, 4'b0111); tick();
        do_res(1, 1'b1); exp_st(1, 1, 1, 4'b0001); exp_rs(map_b); tick();
        exp_st(1, 1, 1, 4'b0001); tick();

        // Wrap-around allocation and circular kill
        do_alloc(map_x); exp_st(2, 1, 2, 4'b0011); tick();
        do_alloc(map_y); exp_st(3, 1, 3, 4'b0111); tick();
        do_res(0, 1'b0); exp_st(2, 1, 3, 4'b0110); tick();
        do_alloc(map_p); exp_st(3, 1, 0, 4'b1110); tick();
        do_alloc(map_q); exp_st(4, 0, 1, 4'b1111); tick();
        do_res(3, 1'b1); exp_st(2, 1, 3, 4'b0110); exp_rs(map_p); tick();
        exp_st(2, 1, 3, 4'b0110); tick();

        // Resolve against an invalid slot is ignored
        do_res(0, 1'b1); exp_st(2, 1, 3, 4'b0110); tick();

        // Mispredict wins over same-cycle alloc
        rst = 1'b1; exp_st(0, 1, 0, 4'b0000); tick();
        do_alloc(map_a); exp_st(1, 1, 1, 4'b0001); tick();
        do_alloc(map_e); do_res(0, 1'b1); exp_st(0, 1, 0, 4'b0000); exp_rs(map_a); tick();
        exp_st(0, 1, 0, 4'b0000); tick();

        // Same-cycle alloc and correct resolve both take effect
        do_alloc(map_a); exp_st(1, 1, 1, 4'b0001); tick();
        do_alloc(map_b); exp_st(2, 1, 2, 4'b0011); tick();
        do_alloc(map_c); do_res(0, 1'b0); exp_st(2, 1, 3, 4'b0110); tick();

        // Flush overrides mispredict and alloc
        flush = 1'b1; do_res(1, 1'b1); do_alloc(map_d); exp_st(0, 1, 0, 4'b0000); tick();
        exp_st(0, 1, 0, 4'b0000); tick();

        // Reset mid-sequence with a pending mispredict
        do_alloc(map_a); exp_st(1, 1, 1, 4'b0001); tick();
        do_alloc(map_b); exp_st(2, 1, 2, 4'b0011); tick();
        do_alloc(map_c); exp_st(3, 1, 3, 4'b0111); tick();
        rst = 1'b1; do_res(1, 1'b1); exp_st(0, 1, 0, 4'b0000); tick();
        exp_st(0, 1, 0, 4'b0000); tick();
        exp_st(0, 1, 0, 4'b0000); tick();

        tick();
        tick();
        checks++;
        if (st_q.size() != 0 || rs_q.size() != 0) begin
            $display("FAIL drain: got %0d status and %0d restore records pending, want 0 and 0",
                     st_q.size(), rs_q.size());
        end else begin
            passed++;
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
